// File: rtl/config_loader_pkg.sv
// Shared types and width helpers for the configuration shift-chain loader.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    SET
  } state_t;

  // Ceiling log2, clamped to 1 so it can size a counter even for tiny ranges.
  function automatic int clog2(input int value);
    int width = 0;
    for (int v = value - 1; v > 0; v = v >> 1) width++;
    return (width < 1) ? 1 : width;
  endfunction

  localparam int DEF_CHAIN_LEN  = 16;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_SET_CYCLES = 1;
  localparam int DEF_BITS_W     = clog2(DEF_CHAIN_LEN + 1);
  localparam int DEF_IDX_W      = clog2(DEF_WORD_W + 1);

endpackage

// File: rtl/config_loader_if.sv
// Bitstream word handshake between the bitstream source and the loader.
interface config_loader_if #(
  parameter int WORD_W = 8
);
  // A word transfers on every clock edge where cfg_valid && cfg_ready are both high;
  // the source holds cfg_data stable until then. cfg_ready is high exactly while the
  // loader is fetching, and a word transferred on the same edge as abort is dropped.
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/config_serializer.sv
// Word register and bit index feeding the chain head, LSB first, one bit per step.
module config_serializer
  import config_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic              keep,
  input  logic [WORD_W-1:0] data,
  output logic              shift_data,
  output logic              word_empty
);

  localparam int IDX_W = clog2(WORD_W + 1);

  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] word_shr;
  logic [IDX_W-1:0]  idx;

  assign word_shr = word_reg >> 1;

  // shift_data always mirrors word_reg[0] while shifting and is forced to 0 otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_reg   <= '0;
      idx        <= '0;
      shift_data <= 1'b0;
    end else if (clear) begin
      word_reg   <= '0;
      idx        <= '0;
      shift_data <= 1'b0;
    end else if (load) begin
      word_reg   <= data;
      idx        <= '0;
      shift_data <= data[0];
    end else if (step) begin
      word_reg   <= word_shr;
      if (idx != IDX_W'(WORD_W)) idx <= idx + IDX_W'(1);
      shift_data <= keep ? word_shr[0] : 1'b0;
    end
  end

  // The bit currently on the wire is the word's last one.
  assign word_empty = (idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/config_loader.sv
// Streams bitstream words into the config tile chain, then pulses set_hard to latch it.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int SET_CYCLES = DEF_SET_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  config_loader_if.slave cfg,
  output logic           shift_enable,
  output logic           shift_data,
  output logic           set_hard,
  output logic           busy,
  output logic           done,
  output state_t         dbg_state
);

  localparam int BITS_W = clog2(CHAIN_LEN + 1);
  localparam int SET_W  = clog2(SET_CYCLES + 1);

  state_t            state, next_state;
  logic [BITS_W-1:0] bits_left;
  logic [SET_W-1:0]  set_cnt;
  logic              cfg_ready_q;
  logic              accept, last_bit, set_last, word_empty;
  logic              step_bit, keep_bit;
  logic              ready_d, shift_en_d, set_hard_d, busy_d, done_d;

  assign accept        = cfg.cfg_valid && cfg_ready_q;
  assign last_bit      = (bits_left == BITS_W'(1));
  assign set_last      = (set_cnt == SET_W'(SET_CYCLES - 1));
  assign step_bit      = (state == SHIFT);
  assign keep_bit      = (next_state == SHIFT);
  assign cfg.cfg_ready = cfg_ready_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cfg_ready_q  <= 1'b0;
      shift_enable <= 1'b0;
      set_hard     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= next_state;
      cfg_ready_q  <= ready_d;
      shift_enable <= shift_en_d;
      set_hard     <= set_hard_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // abort has priority everywhere, including over start in IDLE.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = FETCH;
        FETCH:   if (accept) next_state = SHIFT;
        SHIFT:   if (last_bit) next_state = SET;
                 else if (word_empty) next_state = FETCH;
        SET:     if (set_last) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    ready_d    = (next_state == FETCH);
    shift_en_d = (next_state == SHIFT);
    set_hard_d = (next_state == SET);
    busy_d     = (next_state != IDLE);
    done_d     = done;
    if (abort || (state == IDLE && start)) done_d = 1'b0;
    else if (state == SET && next_state == IDLE) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_left <= '0;
      set_cnt   <= '0;
    end else begin
      if (abort) bits_left <= '0;
      else if (state == IDLE && start) bits_left <= BITS_W'(CHAIN_LEN);
      else if (state == SHIFT && bits_left != '0) bits_left <= bits_left - BITS_W'(1);

      if (abort || state != SET) set_cnt <= '0;
      else if (!set_last) set_cnt <= set_cnt + SET_W'(1);
    end
  end

  config_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .clear      (abort),
    .load       (accept),
    .step       (step_bit),
    .keep       (keep_bit),
    .data       (cfg.cfg_data),
    .shift_data (shift_data),
    .word_empty (word_empty)
  );

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Sequences the configuration shift chain formed by one or more daisy-chained config tiles.
- Takes bitstream words over a valid/ready handshake and serializes them LSB-first onto the chain head (shift_in_hard of the first tile).
- Gates shift_enable so that exactly CHAIN_LEN bits are shifted, then pulses set_hard so every tile latches its configuration.
- Sits between the fabric's bitstream source (boot ROM / JTAG bridge) and the tile column.

Parameters:
- CHAIN_LEN, 16, total bits in the chain. Per tile this is COMB_N + 2 + MEM_N; the value is the sum over all tiles. Must be ≥ 1.
- WORD_W, 8, width of each bitstream word. Must be ≥ 1.
- SET_CYCLES, 1, number of cycles set_hard stays high. Must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a load when in IDLE.
- abort  in  1  cancels a load from any state.
- cfg_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- shift_enable  out  1  drives the shift_enable input of all tiles.
- shift_data  out  1  serial bit to the chain head.
- set_hard  out  1  drives the set_hard input of all tiles.
- busy  out  1  high in any state other than IDLE.
- done  out  1  high after a successful load; held until the next start or abort.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all counters 0. Outputs: cfg_ready=0, shift_enable=0, shift_data=0, set_hard=0, busy=0, done=0.
- Every output is registered.
- States: IDLE, FETCH, SHIFT, SET.
- IDLE:
  - start=1 and abort=0 → FETCH; done cleared; bits_left loaded with CHAIN_LEN.
  - start while busy is ignored.
- FETCH:
  - cfg_ready=1 for the whole state.
  - Handshake: a word is taken on the cycle where cfg_valid && cfg_ready is sampled high. cfg_data is captured into the word register; next state is SHIFT.
  - cfg_valid low: stay in FETCH. No timeout.
- SHIFT:
  - Each cycle: shift_enable=1, shift_data = word_reg[idx]; idx increments and bits_left decrements.
  - Latency: the first bit is presented on the cycle after the accept.
  - idx reaches WORD_W and bits_left > 0 → FETCH. The FETCH cycle is a bubble with shift_enable=0, so the chain holds.
  - bits_left reaches 0 → SET. Any remaining bits of the current word are discarded (partial final word).
- Total words consumed = ceil(CHAIN_LEN / WORD_W). Exactly CHAIN_LEN shift_enable cycles occur per load.
- SET:
  - set_hard=1 and shift_enable=0 for SET_CYCLES cycles.
  - Then → IDLE with done=1, busy=0.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, all outputs deasserted, done=0.
  - A set_hard already in progress is cut short.
  - The chain keeps whatever partial contents it holds; tile outputs are unaffected because no full set completed.
- abort and start in the same cycle in IDLE: abort wins; stay IDLE.
- cfg_valid outside FETCH is ignored; the word is not consumed.
- Reset asserted mid-load: immediate return to IDLE; same effect as abort but asynchronous.
- Width rules:
  - bits_left is clog2(CHAIN_LEN+1) bits.
  - idx is clog2(WORD_W+1) bits.
  - No wrap-around: the counters stop at their terminal values.
- shift_data is don't-care when shift_enable=0, but it is driven 0 so traces stay clean.

Decomposition:
- Package config_loader_pkg holds:
  - state enum (IDLE, FETCH, SHIFT, SET);
  - clog2 helper function;
  - width localparams derived from CHAIN_LEN and WORD_W.
- Sub-module config_serializer, a natural split:
  - contents: word register, bit index, load/shift controls, shift_data output, "word_empty" flag;
  - the top level keeps the FSM, bits_left and the set counter.

Test Plan:
- Exact fit. CHAIN_LEN=16, WORD_W=8; send 0xA5 then 0x3C.
  - Required: shift_data sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - 16 shift_enable cycles, one bubble between words, then set_hard for 1 cycle, then done=1.
- Partial final word. CHAIN_LEN=20, WORD_W=8; send 0xFF, 0x00, 0x0F.
  - Required: exactly 20 shift cycles; the last 4 bits are 1; bits 4–7 of the third word are never shifted.
  - Exactly 3 accepts.
- Source stall. Same setup as exact fit, with cfg_valid low for 5 cycles between words.
  - Required: FETCH holds for 5 cycles with shift_enable=0; the final chain contents are identical to the unstalled case.
- Abort. abort asserted during the 6th shift cycle.
  - Required: next cycle busy=0 and shift_enable=0; set_hard never asserts; done=0.
  - A new start, with a fresh word sequence, completes normally.
- Reset mid-SET. SET_CYCLES=3; drive rst=0 in the 2nd set cycle.
  - Required: set_hard falls immediately, without waiting for a clock edge; all outputs return to reset values.
- Corner cases:
  - start while busy has no effect.
  - start+abort together in IDLE leaves busy=0.
  - cfg_valid asserted in IDLE does not consume the word (its first-bit data does not appear later).
